// File: rtl/rdy_vld_if.sv
// Ready/valid stream bundle; dst is the consuming side.
interface rdy_vld_if #(
  parameter int unsigned DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport src (output valid, output data, input ready);
  modport dst (input valid, input data, output ready);
endinterface

// File: rtl/req_ack_if.sv
// Req/ack stream bundle; src holds req and data until ack.
interface req_ack_if #(
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic              ack;
  logic [DATA_W-1:0] data;

  modport src (output req, output data, input ack);
  modport dst (input req, input data, output ack);
endinterface

// File: rtl/in_and_out_egress.sv
// Egress FIFO behind inAndOut: absorbs the aOut ready/valid stream and re-issues
// items in order on a req/ack interface, with occupancy/transfer/error status.
module in_and_out_egress #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  rdy_vld_if.dst                     aIn,
  req_ack_if.src                     bOut,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [15:0]                xferCount,
  output logic                       ackErr
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned XFER_W = 16;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XFER_W-1:0] xfer_q, xfer_d;
  logic              err_q, err_d;

  logic ready_c;
  logic req_c;
  logic push_c;
  logic pop_c;

  // Handshake decodes come only from the registered count, never from valid/ack.
  assign ready_c = (count_q != CNT_W'(DEPTH));
  assign req_c   = (count_q != CNT_W'(0));
  assign push_c  = aIn.valid & ready_c;
  assign pop_c   = req_c & bOut.ack;

  assign aIn.ready = ready_c;
  assign bOut.req  = req_c;
  // Gate the read mux so stale (unreset) storage never shows while empty.
  assign bOut.data = req_c ? mem_q[rd_ptr_q] : DATA_W'(0);

  assign occupancy = count_q;
  assign xferCount = xfer_q;
  assign ackErr    = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    xfer_d   = xfer_q;
    err_d    = err_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      xfer_d   = xfer_q + XFER_W'(1);
    end

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // An ack with no outstanding request is a consumer protocol violation.
    if (bOut.ack && !req_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      xfer_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      xfer_q   <= xfer_d;
      err_q    <= err_d;
    end
  end

  // Storage is intentionally left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= aIn.data;
    end
  end

endmodule

// File: tb/tb_in_and_out_egress.sv
// Scoreboard bench for in_and_out_egress: stimulus logs accepted items, a monitor
// tracks an abstract FIFO model and compares every cycle mid-period.
module tb_in_and_out_egress;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rdy_vld_if #(.DATA_W(DATA_W)) a_if ();
  req_ack_if #(.DATA_W(DATA_W)) b_if ();

  logic [CNT_W-1:0] occ;
  logic [15:0]      xfer;
  logic             err;

  in_and_out_egress #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .aIn       (a_if),
    .bOut      (b_if),
    .occupancy (occ),
    .xferCount (xfer),
    .ackErr    (err)
  );

  logic [DATA_W-1:0] sb [$];
  int total = 0;
  int bad   = 0;

  int          m_cnt;
  int          m_xfer;
  bit          m_err;
  bit          m_ready, m_req, m_push, m_pop;
  logic [DATA_W-1:0] exp_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 2 time units after negedge, inputs and outputs both stable.
  initial begin
    m_cnt  = 0;
    m_xfer = 0;
    m_err  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        m_cnt  = 0;
        m_xfer = 0;
        m_err  = 1'b0;
        chk("rst_ready", 32'(a_if.ready), 32'd1);
        chk("rst_req",   32'(b_if.req),   32'd0);
        chk("rst_data",  32'(b_if.data),  32'd0);
        chk("rst_occ",   32'(occ),        32'd0);
        chk("rst_xfer",  32'(xfer),       32'd0);
        chk("rst_err",   32'(err),        32'd0);
      end else begin
        m_ready = (m_cnt != int'(DEPTH));
        m_req   = (m_cnt != 0);
        exp_d   = '0;
        if (m_req) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got req with no logged item expected an item at %0t", $time);
          end else begin
            exp_d = sb[0];
          end
        end
        chk("ready", 32'(a_if.ready), 32'(m_ready));
        chk("req",   32'(b_if.req),   32'(m_req));
        chk("data",  32'(b_if.data),  32'(exp_d));
        chk("occ",   32'(occ),        32'(m_cnt));
        chk("xfer",  32'(xfer),       32'(m_xfer));
        chk("err",   32'(err),        32'(m_err));

        m_push = a_if.valid && m_ready;
        m_pop  = m_req && b_if.ack;
        if (b_if.ack && !m_req) m_err = 1'b1;
        if (m_pop) begin
          if (sb.size() > 0) void'(sb.pop_front());
          m_xfer = (m_xfer + 1) % 65536;
        end
        m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      end
    end
  end

  // Drive one cycle at negedge; log the item if it will be accepted at the next edge.
  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit a, input bit free_ack);
    @(negedge clk);
    a_if.valid = v;
    a_if.data  = d;
    if (v && a_if.ready) sb.push_back(d);
    b_if.ack = a && (free_ack || b_if.req);
  endtask

  task automatic step(input int pv, input int pa, input bit free_ack);
    bit v;
    bit a;
    v = (int'($urandom_range(0, 99)) < pv);
    a = (int'($urandom_range(0, 99)) < pa);
    drive(v, DATA_W'($urandom), a, free_ack);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n      = 1'b0;
    a_if.valid = 1'b0;
    b_if.ack   = 1'b0;
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    a_if.valid = 1'b0;
    a_if.data  = '0;
    b_if.ack   = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single item, then a single ack pulse.
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, hold 0x05 against back-pressure, free one slot, then drain.
    for (int i = 1; i <= 4; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
    repeat (3) drive(1'b1, 8'h05, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming: valid and ack held for 20 items across pointer wrap.
    for (int i = 0; i < 20; i++) drive(1'b1, DATA_W'(i), 1'b1, 1'b0);
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic, well-behaved consumer.
    repeat (100) step(80, 20, 1'b0);
    repeat (100) step(20, 80, 1'b0);
    repeat (60)  step(100, 100, 1'b0);
    repeat (150) step(50, 50, 1'b0);

    // Drain, refill to 3, then reset asynchronously mid-cycle.
    repeat (8) drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20 && occ != CNT_W'(3); i++) begin
      drive(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    total++;
    if (occ != CNT_W'(3)) begin
      bad++;
      $display("FAIL fill3_timeout: got occ=%0d expected 3", occ);
    end
    do_reset();
    repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Spurious ack on empty, then a normal transfer, then free-running consumer.
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (200) step(50, 40, 1'b1);

    repeat (8) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
